// File: rtl/scan_loader_pkg.sv
// Shared constants for the scan-chain loader and the core top level.
// Holds the 2-bit FSM state encoding and the default interface and chain sizes.
package scan_loader_pkg;

  // Loader FSM states; the encoding is shared with the top level.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Default chain: 31 memory bytes, 1 button bit and 7 LED bits.
  localparam int unsigned CHAIN_LEN_DEFAULT  = 256;
  localparam int unsigned DATA_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/scan_bit_counter.sv
// Loadable (clear-to-zero) up-counter that saturates at LIMIT.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - synchronous clear to zero (wins over en)
//   en        - count one step
//   last      - high while the count equals LIMIT-1, i.e. the next step
//               reaches the terminal count
module scan_bit_counter #(
  parameter int unsigned LIMIT = 256,
  parameter int unsigned WIDTH = $clog2(LIMIT) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam logic [WIDTH-1:0] LIMIT_C = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] LAST_C  = WIDTH'(LIMIT - 1);
  localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Count register: clears on request, otherwise steps and holds at LIMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (en && (count_r != LIMIT_C)) begin
      count_r <= count_r + ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  assign last = (count_r == LAST_C);

endmodule

// File: rtl/scan_loader.sv
// Byte-to-serial scan-chain loader. Accepts bytes over a valid/ready
// handshake, shifts each one MSB-first into the memory-bank scan chain and
// captures the bits that come back on scan_return into rdata.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   start                  - begin a session (from IDLE or DONE)
//   byte_in/valid/ready    - byte handshake, ready only in LOAD
//   scan_enable, scan_out  - drive the chain while shifting
//   scan_return            - serial data coming back from the chain
//   rdata, rdata_valid     - byte captured during the last shift, 1-cycle strobe
//   busy, done             - session status
module scan_loader
  import scan_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned CHAIN_LEN  = CHAIN_LEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  scan_enable,
  output logic                  scan_out,
  input  logic                  scan_return,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned      SH_W    = $clog2(DATA_WIDTH) + 1;
  localparam logic [SH_W-1:0]  SH_LAST = SH_W'(DATA_WIDTH - 1);
  localparam logic [SH_W-1:0]  SH_ONE  = SH_W'(1);

  state_t                  state_r;
  state_t                  state_s;
  logic [DATA_WIDTH-1:0]   shreg_r;
  logic [SH_W-1:0]         shift_cnt_r;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic                    rdata_valid_r;
  logic                    session_start_s;
  logic                    shifting_s;
  logic                    shift_last_s;
  logic                    chain_last_s;
  logic [DATA_WIDTH-1:0]   shifted_s;

  assign session_start_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign shifting_s      = (state_r == ST_SHIFT);
  assign shift_last_s    = shifting_s && (shift_cnt_r == SH_LAST);
  // Returning bit enters at the LSB so the first bit back ends up as the MSB.
  assign shifted_s       = {shreg_r[DATA_WIDTH-2:0], scan_return};

  scan_bit_counter #(
    .LIMIT (CHAIN_LEN),
    .WIDTH ($clog2(CHAIN_LEN) + 1)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (session_start_s),
    .en    (shifting_s),
    .last  (chain_last_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (byte_valid) state_s = ST_SHIFT;
        else            state_s = ST_LOAD;
      end
      ST_SHIFT: begin
        if (shift_cnt_r == SH_LAST) begin
          if (chain_last_s) state_s = ST_DONE;
          else              state_s = ST_LOAD;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Shift register, per-byte shift counter and capture of the returned byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r       <= '0;
      shift_cnt_r   <= '0;
      rdata_r       <= '0;
      rdata_valid_r <= 1'b0;
    end else begin
      rdata_valid_r <= 1'b0;
      if ((state_r == ST_LOAD) && byte_valid) begin
        shreg_r     <= byte_in;
        shift_cnt_r <= '0;
      end else if (shifting_s) begin
        shreg_r     <= shifted_s;
        shift_cnt_r <= shift_cnt_r + SH_ONE;
        if (shift_last_s) begin
          rdata_r       <= shifted_s;
          rdata_valid_r <= 1'b1;
        end else begin
          rdata_r <= rdata_r;
        end
      end else begin
        shreg_r     <= shreg_r;
        shift_cnt_r <= shift_cnt_r;
      end
    end
  end

  // Output decode from the registered state.
  always_comb begin
    byte_ready  = 1'b0;
    scan_enable = 1'b0;
    scan_out    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_r)
      ST_LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      ST_SHIFT: begin
        scan_enable = 1'b1;
        scan_out    = shreg_r[DATA_WIDTH-1];
        busy        = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: begin
        byte_ready  = 1'b0;
        scan_enable = 1'b0;
      end
    endcase
  end

  assign rdata       = rdata_r;
  assign rdata_valid = rdata_valid_r;

endmodule

// File: tb/tb_scan_loader.sv
// Directed self-checking bench for scan_loader. A 256-bit shift-register
// model stands in for the memory bank chain: bits enter at bit 0 and leave
// from bit 255, so byte k ends at chain[255-8k -: 8], the button at chain[0]
// and the LEDs at chain[7:1].
module tb_scan_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        scan_enable;
  logic        scan_out;
  logic        scan_return;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic        busy;
  logic        done;

  logic         use_chain;
  logic         ret_drive;
  logic         chain_load;
  logic [255:0] chain_init;
  logic [255:0] chain;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign scan_return = use_chain ? chain[255] : ret_drive;

  always @(posedge clk) begin
    if (chain_load) chain <= chain_init;
    else if (scan_enable) chain <= {chain[254:0], scan_out};
  end

  scan_loader #(.DATA_WIDTH(8), .CHAIN_LEN(256)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .scan_enable (scan_enable),
    .scan_out    (scan_out),
    .scan_return (scan_return),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .done        (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; chain_load = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // Waits (bounded) for ready, hands over one byte and runs its 8 shift
  // cycles; returns in the cycle after the last shift.
  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    while (byte_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_checks++;
    if (byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_byte_ready_timeout: byte_ready=%b required 1", byte_ready);
    end
    byte_in = b; byte_valid = 1'b1;
    step();
    byte_valid = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    ret_drive = 1'b0; use_chain = 1'b0; chain_load = 1'b0; chain_init = '0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({byte_ready, scan_enable, scan_out, busy, done, rdata_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 000000",
               {byte_ready, scan_enable, scan_out, busy, done, rdata_valid});
    end
    n_checks++;
    if (rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h required 00", rdata);
    end
    step(); step();
    rst = 1'b0;
    step();
    n_checks++;
    if ({byte_ready, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b required 000", {byte_ready, busy, done});
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] exp_a;
    logic [7:0] exp_r;
    exp_a = 8'hA5;
    exp_r = 8'h3C;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({byte_ready, busy, scan_enable} !== 3'b110) begin
      n_fail++;
      $display("FAIL load_state: ready,busy,se=%b required 110", {byte_ready, busy, scan_enable});
    end
    byte_in = exp_a; byte_valid = 1'b1;
    step();
    byte_valid = 1'b0; byte_in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (scan_enable !== 1'b1 || rdata_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL shift_enable[%0d]: se=%b rv=%b required se=1 rv=0", i, scan_enable, rdata_valid);
      end
      n_checks++;
      if (scan_out !== exp_a[7-i]) begin
        n_fail++;
        $display("FAIL scan_out_bit[%0d]: got %b required %b", i, scan_out, exp_a[7-i]);
      end
      ret_drive = exp_r[7-i];
      step();
    end
    ret_drive = 1'b0;
    n_checks++;
    if ({scan_enable, rdata_valid, byte_ready, done} !== 4'b0110) begin
      n_fail++;
      $display("FAIL after_shift_T9: se,rv,ready,done=%b required 0110",
               {scan_enable, rdata_valid, byte_ready, done});
    end
    n_checks++;
    if (rdata !== exp_r) begin
      n_fail++;
      $display("FAIL rdata_capture: got %h required %h", rdata, exp_r);
    end
    step();
    n_checks++;
    if (rdata_valid !== 1'b0 || rdata !== exp_r) begin
      n_fail++;
      $display("FAIL rdata_hold_T10: rv=%b rdata=%h required rv=0 rdata=%h", rdata_valid, rdata, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_se;
    do_reset();
    start = 1'b1; byte_valid = 1'b1; byte_in = 8'h81;
    #1;
    n_checks++;
    if (byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_not_ready: byte_ready=%b required 0", byte_ready);
    end
    step();
    start = 1'b0;
    n_checks++;
    if ({scan_enable, byte_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL no_accept_in_idle: se,ready=%b required 01", {scan_enable, byte_ready});
    end
    step();
    n_checks++;
    if ({scan_enable, scan_out} !== 2'b11) begin
      n_fail++;
      $display("FAIL accept_next_cycle: se,so=%b required 11", {scan_enable, scan_out});
    end
    for (int c = 1; c < 27; c++) begin
      step();
      exp_se = ((c % 9) != 8);
      n_checks++;
      if (scan_enable !== exp_se || byte_ready !== !exp_se) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: se=%b ready=%b required se=%b ready=%b",
                 c, scan_enable, byte_ready, exp_se, !exp_se);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_full_session();
    do_reset();
    for (int k = 0; k < 32; k++) chain_init[255-8*k -: 8] = 8'h80 + 8'(k);
    chain_load = 1'b1;
    step();
    chain_load = 1'b0;
    use_chain = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 31; i++) send_byte(8'(i));
    n_checks++;
    if ({done, byte_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL not_done_after_31: done,ready=%b required 01", {done, byte_ready});
    end
    send_byte(8'd31);
    n_checks++;
    if ({done, busy, scan_enable, byte_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL done_after_32: done,busy,se,ready=%b required 1000",
               {done, busy, scan_enable, byte_ready});
    end
    n_checks++;
    if (rdata !== 8'h9F || rdata_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL last_return_byte: rdata=%h rv=%b required 9f 1", rdata, rdata_valid);
    end
    n_checks++;
    if (chain[215:208] !== 8'h05 || chain[255:248] !== 8'h00) begin
      n_fail++;
      $display("FAIL memory_addr5_addr0: got %h %h required 05 00", chain[215:208], chain[255:248]);
    end
    n_checks++;
    if (chain[7:1] !== 7'h0F || chain[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL led_button: led=%h btn=%b required 0f 1", chain[7:1], chain[0]);
    end
    repeat (3) step();
    n_checks++;
    if ({done, scan_enable, rdata_valid} !== 3'b100 || rdata !== 8'h9F) begin
      n_fail++;
      $display("FAIL done_hold: done,se,rv=%b rdata=%h required 100 9f",
               {done, scan_enable, rdata_valid}, rdata);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({done, busy, byte_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL restart_from_done: done,busy,ready=%b required 011", {done, busy, byte_ready});
    end
    use_chain = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    ret_drive = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    byte_in = 8'hFF; byte_valid = 1'b1;
    step();
    byte_valid = 1'b0;
    step(); step(); step();
    n_checks++;
    if ({scan_enable, scan_out} !== 2'b11 || rdata !== 8'hFF) begin
      n_fail++;
      $display("FAIL pre_reset_shift4: se,so=%b rdata=%h required 11 ff", {scan_enable, scan_out}, rdata);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({byte_ready, scan_enable, scan_out, busy, done, rdata_valid} !== 6'b0 || rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_shift_reset: outs=%b rdata=%h required 000000 00",
               {byte_ready, scan_enable, scan_out, busy, done, rdata_valid}, rdata);
    end
    step();
    rst = 1'b0;
    ret_drive = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 31; i++) send_byte(8'(i));
    n_checks++;
    if ({done, byte_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL restart_count_31: done,ready=%b required 01", {done, byte_ready});
    end
    send_byte(8'd31);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_count_32: done=%b required 1", done);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_session();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_loader.md
SCAN_LOADER -- requirements
Module: scan_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the byte interface.
REQ-002 Parameter CHAIN_LEN, default 256, SHALL set the total scan-chain length in bits (31x8 memory + 1 button + 7 LED); it SHALL be a multiple of DATA_WIDTH.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begins a load session.
REQ-006 byte_in  input  DATA_WIDTH  byte to shift into the chain.
REQ-007 byte_valid  input  1  byte_in is valid.
REQ-008 byte_ready  output  1  loader can accept a byte.
REQ-009 scan_enable  output  1  drives the memory bank scan_enable.
REQ-010 scan_out  output  1  serial data to the memory bank scan_in.
REQ-011 scan_return  input  1  serial data from the memory bank scan_out.
REQ-012 rdata  output  DATA_WIDTH  byte captured from scan_return during the last shift.
REQ-013 rdata_valid  output  1  one-cycle strobe that rdata is new.
REQ-014 busy  output  1  high in LOAD or SHIFT.
REQ-015 done  output  1  high in DONE.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-017 IDLE or DONE with start=1 SHALL go to LOAD and clear the chain bit counter to 0.
REQ-018 start in LOAD or SHIFT SHALL be ignored.
REQ-019 byte_ready SHALL be combinationally 1 only in LOAD; in all other states it SHALL be 0, so byte_valid in IDLE is not accepted even when start=1 in the same cycle.
REQ-020 Handshake: a byte SHALL be accepted on the edge where byte_valid=1 and byte_ready=1; byte_in is loaded into the shift register and the state moves to SHIFT.
REQ-021 SHIFT SHALL last exactly DATA_WIDTH cycles, with scan_enable=1 in each and 0 in all other states.
REQ-022 In each SHIFT cycle scan_out SHALL equal the shift register MSB; on each edge the register shifts left with scan_return entering the LSB (MSB of byte goes out first).
REQ-023 scan_out SHALL be 0 outside SHIFT.
REQ-024 On the edge ending the last SHIFT cycle, rdata SHALL take the full shift-register contents, and rdata_valid SHALL be 1 for exactly the following cycle.
REQ-025 Latency: for a byte accepted at edge T, scan_enable SHALL be high in cycles T+1..T+8 and rdata_valid high in cycle T+9 (DATA_WIDTH=8).
REQ-026 The bit counter SHALL count SHIFT cycles (width clog2(CHAIN_LEN)+1, no wrap). After the last SHIFT cycle the state SHALL go to DONE if the counter reaches CHAIN_LEN, otherwise to LOAD.
REQ-027 DONE SHALL hold done=1 and scan_enable=0 until start.
REQ-028 rdata SHALL hold its value until the next capture.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, bit counter 0, shift register 0, rdata 0, and rdata_valid, scan_enable, scan_out, byte_ready, busy, done all 0.
REQ-030 Reset mid-SHIFT SHALL drop scan_enable without waiting for a clock edge; the partial byte is discarded.

Structure
REQ-031 The state encodings (2-bit) and the default CHAIN_LEN SHALL live in the shared qtcore constants package/include, used by both this block and the top level.
REQ-032 One sub-module, scan_bit_counter (a loadable up-counter with a terminal-count flag), is natural; the rest SHALL be inline.

Verification
REQ-033 Reset then start, one byte 8'hA5 -> scan_out sequence 1,0,1,0,0,1,0,1 over 8 scan_enable cycles, with scan_enable high for T+1..T+8.
REQ-034 scan_return driven with the bits of 8'h3C during the shift -> rdata=8'h3C, and rdata_valid high for exactly cycle T+9.
REQ-035 Full session of 32 bytes into a memory_bank instance, each byte value = index -> done=1 after byte 32; the memory bank then reads address 5 as 8'h05 (matching the chain ordering) and led_out equals the upper 7 bits of byte 31.
REQ-036 byte_valid=1 held continuously -> back-to-back bytes with exactly one LOAD cycle between SHIFT bursts.
REQ-037 start and byte_valid asserted together in IDLE -> no byte accepted that cycle; the byte is accepted on the next cycle.
REQ-038 rst pulsed during the 4th SHIFT cycle of byte 3 -> all outputs 0 at once; a new start restarts with counter 0.
